// File: rtl/dbg_loader_pkg.sv
// rtl/dbg_loader_pkg.sv - shared opcodes, FSM states and helpers for the debug memory loader
package dbg_loader_pkg;

    localparam logic [7:0] OP_WR_INST   = 8'h01;
    localparam logic [7:0] OP_RD_INST   = 8'h02;
    localparam logic [7:0] OP_WR_DATA   = 8'h03;
    localparam logic [7:0] OP_RD_DATA   = 8'h04;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        RWAIT,
        SEND,
        ERR
    } state_t;

    function automatic logic op_valid(input logic [7:0] op);
        return (op == OP_WR_INST) || (op == OP_RD_INST) ||
               (op == OP_WR_DATA) || (op == OP_RD_DATA);
    endfunction

    // Debug ports are word addressed; the low two address bits are dropped
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dbg_mem_loader_if.sv
// rtl/dbg_mem_loader_if.sv - byte streams and cache debug ports of the loader
interface dbg_mem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] dbg_inst_a2;
    logic [31:0] dbg_inst_wd2;
    logic [3:0]  dbg_inst_we2;
    logic [31:0] dbg_inst_rd2;
    logic [31:0] dbg_data_a2;
    logic [31:0] dbg_data_wd2;
    logic [3:0]  dbg_data_we2;
    logic [31:0] dbg_data_rd2;
    logic        busy;
    logic        err;

    modport master (
        input  rx_data, rx_valid, tx_ready, dbg_inst_rd2, dbg_data_rd2,
        output rx_ready, tx_data, tx_valid,
        output dbg_inst_a2, dbg_inst_wd2, dbg_inst_we2,
        output dbg_data_a2, dbg_data_wd2, dbg_data_we2,
        output busy, err
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dbg_inst_rd2, dbg_data_rd2,
        input  rx_ready, tx_data, tx_valid,
        input  dbg_inst_a2, dbg_inst_wd2, dbg_inst_we2,
        input  dbg_data_a2, dbg_data_wd2, dbg_data_we2,
        input  busy, err
    );
endinterface

// File: rtl/dbg_tx_serializer.sv
// rtl/dbg_tx_serializer.sv - emits a 1- or 4-byte response LSB-first over valid/ready
module dbg_tx_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [2:0]  nbytes,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);
    logic [31:0] shreg;
    logic [2:0]  left;

    // Load a response word, then shift one byte out per accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            left     <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg    <= word;
            left     <= nbytes;
            tx_valid <= (nbytes != 3'd0);
        end else if (tx_valid && tx_ready) begin
            shreg <= {8'h00, shreg[31:8]};
            left  <= left - 3'd1;
            if (left == 3'd1) begin
                tx_valid <= 1'b0;
            end
        end
    end

    // The byte on the wire comes from a register, so it holds under backpressure
    assign tx_data = shreg[7:0];
    assign done    = tx_valid && tx_ready && (left == 3'd1);

endmodule

// File: rtl/dbg_mem_loader.sv
// rtl/dbg_mem_loader.sv - byte-command master for the inst/data cache debug ports
module dbg_mem_loader
    import dbg_loader_pkg::*;
#(
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE   = ERR_BYTE_DEF
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    dbg_mem_loader_if.master bus
);
    state_t      state;
    state_t      state_nxt;
    logic [7:0]  opcode;
    logic [1:0]  cnt;
    logic [1:0]  lat_cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] inst_a2;
    logic [31:0] inst_wd2;
    logic [31:0] data_a2;
    logic [31:0] data_wd2;
    logic        rx_hs;
    logic        sel_inst;
    logic        is_write;
    logic [31:0] addr_shift;
    logic [31:0] data_shift;
    logic        ser_load;
    logic [31:0] ser_word;
    logic [2:0]  ser_nbytes;
    logic        ser_done;

    assign rx_hs      = bus.rx_valid && bus.rx_ready;
    assign sel_inst   = (opcode == OP_WR_INST) || (opcode == OP_RD_INST);
    assign is_write   = (opcode == OP_WR_INST) || (opcode == OP_WR_DATA);
    assign addr_shift = {bus.rx_data, addr[31:8]};
    assign data_shift = {bus.rx_data, wdata[31:8]};

    // State register
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode of the command protocol
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (rx_hs) state_nxt = op_valid(bus.rx_data) ? ADDR : ERR;
            ADDR:  if (rx_hs && cnt == 2'd3) state_nxt = is_write ? DATA : RWAIT;
            DATA:  if (rx_hs && cnt == 2'd3) state_nxt = WRITE;
            WRITE: state_nxt = SEND;
            RWAIT: if (lat_cnt == 2'd0) state_nxt = SEND;
            ERR:   state_nxt = SEND;
            SEND:  if (ser_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command shift registers and held debug-port address/data
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            opcode   <= '0;
            cnt      <= '0;
            lat_cnt  <= '0;
            addr     <= '0;
            wdata    <= '0;
            inst_a2  <= '0;
            inst_wd2 <= '0;
            data_a2  <= '0;
            data_wd2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_hs) begin
                        opcode <= bus.rx_data;
                        cnt    <= 2'd0;
                    end
                end
                ADDR: begin
                    if (rx_hs) begin
                        addr <= addr_shift;
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3 && !is_write) begin
                            lat_cnt <= 2'(RD_LATENCY);
                            if (sel_inst) inst_a2 <= word_align(addr_shift);
                            else          data_a2 <= word_align(addr_shift);
                        end
                    end
                end
                DATA: begin
                    if (rx_hs) begin
                        wdata <= data_shift;
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (sel_inst) begin
                                inst_a2  <= word_align(addr);
                                inst_wd2 <= data_shift;
                            end else begin
                                data_a2  <= word_align(addr);
                                data_wd2 <= data_shift;
                            end
                        end
                    end
                end
                RWAIT: lat_cnt <= lat_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    // Per-state outputs: handshakes, write strobes and response loading
    always_comb begin
        bus.rx_ready     = (state == IDLE) || (state == ADDR) || (state == DATA);
        bus.busy         = (state != IDLE);
        bus.err          = (state == ERR);
        bus.dbg_inst_we2 = (state == WRITE && sel_inst)  ? 4'b1111 : 4'b0000;
        bus.dbg_data_we2 = (state == WRITE && !sel_inst) ? 4'b1111 : 4'b0000;
        ser_load         = 1'b0;
        ser_word         = '0;
        ser_nbytes       = 3'd0;
        case (state)
            WRITE: begin
                ser_load   = 1'b1;
                ser_word   = {24'h0, ACK_BYTE};
                ser_nbytes = 3'd1;
            end
            ERR: begin
                ser_load   = 1'b1;
                ser_word   = {24'h0, ERR_BYTE};
                ser_nbytes = 3'd1;
            end
            RWAIT: begin
                if (lat_cnt == 2'd0) begin
                    ser_load   = 1'b1;
                    ser_word   = sel_inst ? bus.dbg_inst_rd2 : bus.dbg_data_rd2;
                    ser_nbytes = 3'd4;
                end
            end
            default: ;
        endcase
    end

    assign bus.dbg_inst_a2  = inst_a2;
    assign bus.dbg_inst_wd2 = inst_wd2;
    assign bus.dbg_data_a2  = data_a2;
    assign bus.dbg_data_wd2 = data_wd2;

    dbg_tx_serializer u_ser (
        .clk      (CPU_CLK),
        .rst      (CPU_RST),
        .load     (ser_load),
        .word     (ser_word),
        .nbytes   (ser_nbytes),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .tx_ready (bus.tx_ready),
        .done     (ser_done)
    );

endmodule

// File: doc/dbg_mem_loader.md
Name: dbg_mem_loader

Overview:
- Host-side master for the core's cache debug ports: inst-cache and data-cache A2/WD2/WE2/RD2.
- Parses a byte-stream command protocol from a UART-style receiver and performs single-word debug writes and reads.
- Returns read data or acknowledgements as a byte stream.
- Sits between the board UART and the RV32I core top. Lets the test host load programs into the instruction cache and dump the data cache.

Parameters:
- RD_LATENCY, 1, cycles from A2 valid to RD2 valid on the debug read port (1..3).
- ACK_BYTE, 8'hAA, response byte sent after a completed write.
- ERR_BYTE, 8'hEE, response byte sent for an unknown opcode.

Ports:
- CPU_CLK  in  1  clock
- CPU_RST  in  1  reset; asynchronous, active-high
- rx_data  in  8  command byte from receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte (transfer when rx_valid&rx_ready)
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- dbg_inst_a2  out  32  inst-cache debug address
- dbg_inst_wd2  out  32  inst-cache debug write data
- dbg_inst_we2  out  4  inst-cache debug byte write enables
- dbg_inst_rd2  in  32  inst-cache debug read data
- dbg_data_a2  out  32  data-cache debug address
- dbg_data_wd2  out  32  data-cache debug write data
- dbg_data_we2  out  4  data-cache debug byte write enables
- dbg_data_rd2  in  32  data-cache debug read data
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset (async, CPU_CLK domain): state=IDLE.
  - All outputs 0, except rx_ready=1.
  - Byte counter 0; address and data shift registers 0.
- Protocol:
  - Command = opcode byte, then 4 address bytes LSB-first.
  - Write commands then carry 4 data bytes LSB-first.
  - Opcodes: 8'h01 write inst, 8'h02 read inst, 8'h03 write data, 8'h04 read data.
- Address handling:
  - Address bits [1:0] forced to 0 on the a2 outputs.
  - The unselected cache's a2/wd2 hold their last value; its we2 stays 0.
- FSM states: IDLE, ADDR, DATA, WRITE, RWAIT, SEND, ERR.
- IDLE: on rx handshake latch opcode.
  - Valid opcode: go to ADDR, cnt=0.
  - Invalid opcode: go to ERR.
- ADDR: shift in 4 bytes (addr = {rx_data, addr[31:8]}).
  - After the 4th byte: write opcode goes to DATA; read opcode goes to RWAIT.
- DATA: shift in 4 bytes the same way into wdata, then go to WRITE.
- WRITE:
  - Exactly one cycle: selected we2=4'b1111, a2=addr, wd2=wdata.
  - Next state SEND with a 1-byte response (ACK_BYTE).
- RWAIT:
  - Drive a2 and wait RD_LATENCY cycles (down-counter).
  - Capture the selected rd2 into rdata; go to SEND with a 4-byte response LSB-first.
- SEND:
  - tx_valid=1 and tx_data=current byte.
  - Advance on tx_ready; after the last byte go to IDLE.
  - tx_data must be stable while tx_valid=1 and tx_ready=0.
- ERR:
  - err pulses on the entry cycle.
  - Send ERR_BYTE through the SEND path, then go to IDLE.
- rx_ready:
  - 1 only in IDLE, ADDR and DATA; 0 otherwise.
  - Bytes are never dropped: the sender must hold rx_valid.
- Latency:
  - Write: WRITE occurs the cycle after the 9th byte handshake.
  - Read: tx_valid rises RD_LATENCY+1 cycles after the 5th byte handshake.
- Simultaneous events: rx_valid during SEND is ignored (rx_ready=0); there is no pipelining of the next command.
- Reset mid-command:
  - Immediate return to IDLE; any partial command is discarded.
  - we2 deasserts asynchronously.
- The loader does not stall the core; the host keeps the core in reset while loading.

Decomposition:
- Shared package dbg_loader_pkg:
  - Opcode constants OP_WR_INST, OP_RD_INST, OP_WR_DATA, OP_RD_DATA.
  - FSM state enum.
  - Default ACK/ERR byte constants.
- One natural sub-module, dbg_tx_serializer:
  - Loads a 32-bit word plus a byte count (1 or 4).
  - Emits bytes LSB-first over the tx valid/ready handshake.
  - Signals done.

Test Plan:
- Write inst: 01,00,01,00,00,13,05,10,00 → one cycle with dbg_inst_we2=4'hF, a2=32'h00000100, wd2=32'h00100513; tx 8'hAA; dbg_data_we2 stays 0.
- Read data with rd2 model returning 32'hDEADBEEF at addr 32'h20 → bytes 04,20,00,00,00 → tx EF,BE,AD,DE; tx_valid rises RD_LATENCY+1 cycles after the 5th byte.
- Unaligned addr: write data to 32'h00000023 → dbg_data_a2=32'h00000020.
- Backpressure: hold tx_ready=0 for 10 cycles during a read response → tx_data stable and rx_ready=0 throughout; all 4 bytes delivered in order once released.
- Bad opcode 8'h7F → err pulse for 1 cycle; tx 8'hEE; next valid command processed normally.
- Assert CPU_RST after 3 address bytes → outputs zero immediately, rx_ready=1; a following full read command returns correct data.
